// File: rtl/softmax_max_sub.sv
// softmax_max_sub: buffers one fp16 softmax vector, tracks its maximum while
// loading, then streams (x_i - max) one element per handshake to the
// exponent stage. The subtractor is a self-contained fp16 IEEE-754 core with
// round-to-nearest-even, gradual underflow and a DesignWare-style status byte
// {2'b0, inexact, huge, tiny, invalid, infinity, zero}.
module softmax_max_sub #(
  parameter int VEC_LEN    = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            out_status,
  output logic                  out_last
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VEC_LEN - 1);
  localparam int                    DEPTH    = 2 ** ADDR_WIDTH;

  // Ordering key: maps fp16 to an unsigned value that sorts numerically,
  // with -0 placed just below +0.
  function automatic logic [15:0] fp16_key(input logic [15:0] x);
    logic [15:0] k;
    if (x[15]) begin
      k = ~x;
    end else begin
      k = x ^ 16'h8000;
    end
    return k;
  endfunction

  // fp16 a - b, RNE. Returns {status[7:0], result[15:0]}.
  function automatic logic [23:0] fp16_sub(input logic [15:0] a, input logic [15:0] b);
    logic        sa, sb, eff_sub, a_big, sl, found;
    logic [4:0]  ea, eb, el, es, d, lz, shamt;
    logic [10:0] ma, mb, ml, ms;
    logic [27:0] sh;
    logic [13:0] s_al, norm;
    logic [14:0] sum;
    logic [5:0]  en;
    logic        g, r, s, rnd_up, inexact;
    logic [15:0] pre, rounded, res;
    logic [7:0]  st;
    sa      = a[15];
    sb      = ~b[15];
    ea      = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
    eb      = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
    ma      = {(a[14:10] != 5'd0), a[9:0]};
    mb      = {(b[14:10] != 5'd0), b[9:0]};
    a_big   = (a[14:0] >= b[14:0]);
    eff_sub = sa ^ sb;
    el      = a_big ? ea : eb;
    es      = a_big ? eb : ea;
    ml      = a_big ? ma : mb;
    ms      = a_big ? mb : ma;
    sl      = a_big ? sa : sb;
    // Align the smaller operand; everything shifted past the round bit
    // collapses into a sticky LSB.
    d = el - es;
    if (d > 5'd14) begin
      d = 5'd14;
    end else begin
      d = d;
    end
    sh   = {ms, 3'b000, 14'b0} >> d;
    s_al = sh[27:14] | {13'b0, (|sh[13:0])};
    if (eff_sub) begin
      sum = {1'b0, ml, 3'b000} - {1'b0, s_al};
    end else begin
      sum = {1'b0, ml, 3'b000} + {1'b0, s_al};
    end
    // Normalise: carry-out shifts right, cancellation shifts left but never
    // below the minimum exponent (result becomes subnormal instead).
    lz    = 5'd14;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(13 - i);
        found = 1'b1;
      end
    end
    if (sum[14]) begin
      shamt = 5'd0;
      norm  = {sum[14:2], (sum[1] | sum[0])};
      en    = {1'b0, el} + 6'd1;
    end else begin
      shamt = (lz < (el - 5'd1)) ? lz : (el - 5'd1);
      norm  = sum[13:0] << shamt;
      en    = {1'b0, el} - {1'b0, shamt};
    end
    g       = norm[2];
    r       = norm[1];
    s       = norm[0];
    rnd_up  = g & (r | s | norm[3]);
    inexact = g | r | s;
    // Packing exponent and fraction lets the rounding carry ripple into the
    // exponent (subnormal->normal, mantissa overflow, overflow to Inf).
    pre     = {(norm[13] ? en : 6'd0), norm[12:3]};
    rounded = pre + {15'b0, rnd_up};
    if (sum == 15'd0) begin
      res = {(eff_sub ? 1'b0 : sa), 15'b0};
      st  = 8'b0000_0001;
    end else if (rounded[15:10] >= 6'd31) begin
      res = {sl, 5'h1f, 10'h000};
      st  = 8'b0011_0010;
    end else begin
      res = {sl, rounded[14:0]};
      st  = {2'b00, inexact, 1'b0, (rounded[14:10] == 5'd0), 3'b000};
    end
    return {st, res};
  endfunction

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, rd_cnt_q;
  logic [15:0]           max_q, max_d;
  logic [15:0]           vec_q [DEPTH];
  logic                  in_ready_q, out_valid_q, out_last_q;
  logic [15:0]           out_data_q;
  logic [7:0]            out_status_q;

  logic                  in_acc_s, out_acc_s;
  logic [ADDR_WIDTH-1:0] rd_nxt_s;
  logic [15:0]           sub_a_s, sub_b_s;
  logic [23:0]           sub_res_s;

  assign in_acc_s  = in_valid & in_ready_q;
  assign out_acc_s = out_valid_q & out_ready;
  assign sub_res_s = fp16_sub(sub_a_s, sub_b_s);

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_status = out_status_q;
  assign out_last   = out_last_q;

  // Running max and subtractor operand selection (element 0 on entry to
  // EMIT using the final max, otherwise the next element to emit).
  always_comb begin
    max_d    = max_q;
    rd_nxt_s = rd_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    sub_a_s  = 16'h0000;
    sub_b_s  = 16'h0000;
    if (in_acc_s) begin
      if (wr_cnt_q == '0) begin
        max_d = in_data;
      end else if (fp16_key(in_data) > fp16_key(max_q)) begin
        max_d = in_data;
      end else begin
        max_d = max_q;
      end
    end else begin
      max_d = max_q;
    end
    if (state_q == ST_LOAD) begin
      sub_a_s = vec_q[0];
      sub_b_s = max_d;
    end else begin
      sub_a_s = vec_q[rd_nxt_s];
      sub_b_s = max_q;
    end
  end

  // Element buffer; contents need no reset.
  always_ff @(posedge clk) begin
    if (in_acc_s) begin
      vec_q[wr_cnt_q] <= in_data;
    end
  end

  // Control FSM with registered handshake and output data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      max_q        <= 16'h0000;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= 16'h0000;
      out_status_q <= 8'h00;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_acc_s) begin
            max_q <= max_d;
            if (wr_cnt_q == LAST_IDX) begin
              wr_cnt_q     <= '0;
              rd_cnt_q     <= '0;
              state_q      <= ST_EMIT;
              in_ready_q   <= 1'b0;
              out_valid_q  <= 1'b1;
              out_last_q   <= 1'b0;
              out_data_q   <= sub_res_s[15:0];
              out_status_q <= sub_res_s[23:16];
            end else begin
              wr_cnt_q <= wr_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_EMIT: begin
          if (out_acc_s) begin
            if (rd_cnt_q == LAST_IDX) begin
              rd_cnt_q    <= '0;
              state_q     <= ST_LOAD;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              rd_cnt_q     <= rd_nxt_s;
              out_last_q   <= (rd_nxt_s == LAST_IDX);
              out_data_q   <= sub_res_s[15:0];
              out_status_q <= sub_res_s[23:16];
            end
          end
        end
        default: begin
          state_q     <= ST_LOAD;
          wr_cnt_q    <= '0;
          rd_cnt_q    <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_max_sub.sv
// Bench for softmax_max_sub: directed vectors plus randomized vectors,
// checked against a real-arithmetic reference of max and x - max.
module tb_softmax_max_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_status;
  logic        out_last;

  int total = 0;
  int bad   = 0;

  logic [15:0] vec [4];

  softmax_max_sub #(.VEC_LEN(4), .ADDR_WIDTH(2), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [15:0] h);
    int  e;
    int  mi;
    real m;
    e  = int'(h[14:10]);
    mi = int'(h[9:0]);
    if (e == 0) begin
      e = 1;
    end else begin
      mi = mi + 1024;
    end
    m = real'(mi) * pow2(e - 25);
    return h[15] ? -m : m;
  endfunction

  // Numeric order with -0 below +0.
  function automatic bit fp_gt(input logic [15:0] a, input logic [15:0] b);
    return (f2r(a) > f2r(b)) || (a == 16'h0000 && b == 16'h8000);
  endfunction

  // Exact difference in double precision, then rounded to fp16 (RNE).
  task automatic ref_sub(input logic [15:0] x, input logic [15:0] mx,
                         output logic [15:0] res, output logic [7:0] st);
    real d, m, sc, fr;
    int  e, iq;
    bit  sg;
    d = f2r(x) - f2r(mx);
    if (d == 0.0) begin
      res = (x[15] && !mx[15]) ? 16'h8000 : 16'h0000;
      st  = 8'h01;
    end else begin
      sg = (d < 0.0);
      m  = sg ? -d : d;
      if (m < pow2(-14)) begin
        iq  = $rtoi(m * pow2(24));
        res = {sg, 5'd0, iq[9:0]};
        st  = 8'h08;
      end else begin
        e = -14;
        while (m >= pow2(e + 1)) e++;
        sc = m * pow2(10 - e);
        iq = $rtoi(sc);
        fr = sc - real'(iq);
        if (fr > 0.5 || (fr == 0.5 && (iq % 2) == 1)) iq++;
        if (iq == 2048) begin
          iq = 1024;
          e++;
        end
        if (e > 15) begin
          res = {sg, 5'h1f, 10'h000};
          st  = 8'h32;
        end else begin
          iq  = iq - 1024;
          res = {sg, 5'(e + 15), iq[9:0]};
          st  = (fr != 0.0) ? 8'h20 : 8'h00;
        end
      end
    end
  endtask

  function automatic logic [15:0] rand_fp16();
    logic [4:0] e;
    e = 5'($urandom_range(0, 30));
    return {1'($urandom_range(0, 1)), e, 10'($urandom)};
  endfunction

  // Load vec[] (gap idle cycles before each element) and drain n_out results.
  task automatic run_vec(input string nm, input int gap, input int stall_idx,
                         input int stall_len, input bit junk, input bit rnd_stall,
                         input int n_out);
    logic [15:0] mx;
    logic [15:0] er [4];
    logic [7:0]  es [4];
    int          ns;
    mx = vec[0];
    for (int i = 1; i < 4; i++) if (fp_gt(vec[i], mx)) mx = vec[i];
    for (int i = 0; i < 4; i++) ref_sub(vec[i], mx, er[i], es[i]);
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        tick();
      end
      chk($sformatf("%s.in_ready%0d", nm, i), 16'(in_ready), 16'd1);
      chk($sformatf("%s.ovalid_load%0d", nm, i), 16'(out_valid), 16'd0);
      in_valid = 1'b1;
      in_data  = vec[i];
      tick();
    end
    in_valid = 1'b0;
    chk($sformatf("%s.first_valid", nm), 16'(out_valid), 16'd1);
    for (int i = 0; i < n_out; i++) begin
      chk($sformatf("%s.valid%0d", nm, i), 16'(out_valid), 16'd1);
      chk($sformatf("%s.iready_emit%0d", nm, i), 16'(in_ready), 16'd0);
      chk($sformatf("%s.data%0d", nm, i), out_data, er[i]);
      chk($sformatf("%s.status%0d", nm, i), {8'h00, out_status}, {8'h00, es[i]});
      chk($sformatf("%s.last%0d", nm, i), 16'(out_last), 16'(i == 3));
      ns = (i == stall_idx) ? stall_len : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
      for (int k = 0; k < ns; k++) begin
        out_ready = 1'b0;
        in_valid  = junk;
        in_data   = 16'($urandom);
        tick();
        chk($sformatf("%s.hold_data%0d", nm, i), out_data, er[i]);
        chk($sformatf("%s.hold_valid%0d", nm, i), 16'(out_valid), 16'd1);
        chk($sformatf("%s.hold_iready%0d", nm, i), 16'(in_ready), 16'd0);
      end
      out_ready = 1'b1;
      in_valid  = junk;
      in_data   = 16'($urandom);
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end
    if (n_out == 4) begin
      chk($sformatf("%s.reload_iready", nm), 16'(in_ready), 16'd1);
      chk($sformatf("%s.reload_ovalid", nm), 16'(out_valid), 16'd0);
    end
  endtask

  task automatic set_vec(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    vec[0] = a;
    vec[1] = b;
    vec[2] = c;
    vec[3] = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst.in_ready", 16'(in_ready), 16'd1);
    chk("rst.out_valid", 16'(out_valid), 16'd0);
    chk("rst.out_last", 16'(out_last), 16'd0);

    set_vec(16'h3C00, 16'h4000, 16'hBC00, 16'h3800);
    run_vec("t1", 0, -1, 0, 1'b0, 1'b0, 4);
    set_vec(16'hB800, 16'hC000, 16'hB400, 16'hC400);
    run_vec("t2", 0, -1, 0, 1'b0, 1'b0, 4);
    set_vec(16'h4000, 16'h3C00, 16'h4000, 16'h4000);
    run_vec("t3", 0, -1, 0, 1'b0, 1'b0, 4);
    set_vec(16'h8000, 16'h0000, 16'h8000, 16'h0000);
    run_vec("t3z", 0, -1, 0, 1'b0, 1'b0, 4);
    set_vec(16'h3C00, 16'h4000, 16'hBC00, 16'h3800);
    run_vec("t4", 0, 1, 5, 1'b1, 1'b0, 4);
    run_vec("t5a", 2, -1, 0, 1'b0, 1'b0, 4);
    set_vec(16'hB800, 16'hC000, 16'hB400, 16'hC400);
    run_vec("t5b", 2, -1, 0, 1'b0, 1'b0, 4);

    // Asynchronous reset with rd_cnt at 2.
    set_vec(16'h3C00, 16'h4000, 16'hBC00, 16'h3800);
    run_vec("t6a", 0, -1, 0, 1'b0, 1'b0, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.rst_ovalid", 16'(out_valid), 16'd0);
    chk("t6.rst_iready", 16'(in_ready), 16'd1);
    chk("t6.rst_last", 16'(out_last), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_vec("t6b", 0, -1, 0, 1'b0, 1'b0, 4);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0 && $urandom_range(0, 4) == 0) vec[i] = vec[$urandom_range(0, i - 1)];
        else if ($urandom_range(0, 9) == 0) vec[i] = $urandom_range(0, 1) ? 16'h8000 : 16'h0000;
        else vec[i] = rand_fp16();
      end
      run_vec($sformatf("r%0d", n), int'($urandom_range(0, 2)), -1, 0,
              1'($urandom_range(0, 1)), 1'b1, 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
